// File: rtl/game_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller.
package game_pkg;

  // Controller states
  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_TURN  = 3'd1,
    S_WRITE = 3'd2,
    S_EVAL  = 3'd3,
    S_DONE  = 3'd4
  } game_state_e;

  // Winner codes
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_BLUE = 2'b01;
  localparam logic [1:0] WIN_RED  = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Board geometry
  localparam logic [3:0] CENTER_SLOT = 4'd4;
  localparam logic [3:0] LAST_SLOT   = 4'd8;
  localparam logic [8:0] FULL_BOARD  = 9'h1FF;

  // The eight winning lines: three rows, three columns, two diagonals
  localparam int NUM_LINES = 8;
  localparam logic [8:0] WIN_LINES [NUM_LINES] = '{
    9'h007,  // slots 0-1-2
    9'h038,  // slots 3-4-5
    9'h1C0,  // slots 6-7-8
    9'h049,  // slots 0-3-6
    9'h092,  // slots 1-4-7
    9'h124,  // slots 2-5-8
    9'h111,  // slots 0-4-8
    9'h054   // slots 2-4-6
  };

endpackage

// File: rtl/game_ctrl_win_check.sv
// Combinational line detector: flags when any winning line is fully covered
// by a player's occupancy vector.
module win_check
  import game_pkg::*;
(
  input  logic [8:0] occ,
  output logic       line_done
);

  // OR-reduce the per-line "all three slots owned" tests
  always_comb begin
    line_done = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if ((occ & WIN_LINES[i]) == WIN_LINES[i]) line_done = 1'b1;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Turn sequencer for the board register file: cursor movement, move
// validation, single-cycle slot writes, win/draw evaluation and board clear.
// Board interface: a write happens on every rising edge where we = 1, using
// player/offset as the address and data_in as data; there is no backpressure.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TURN_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        clr_game_n,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        select,
  input  logic        new_game,
  input  logic        taken,
  input  logic [8:0]  b_out,
  input  logic [8:0]  r_out,
  output logic        player,
  output logic [3:0]  offset,
  output logic        we,
  output logic        data_in,
  output logic        clr_game,
  output logic        illegal,
  output logic [1:0]  winner,
  output logic        game_over,
  output game_state_e state_dbg
);

  // Counter only needs to hold 0..TURN_TIMEOUT-1
  localparam int CW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TURN_TIMEOUT - 1);

  game_state_e   state;
  logic [CW-1:0] turn_cnt;
  logic [8:0]    cur_occ;
  logic          line_done;
  logic          timeout_hit;

  // Evaluate only the player who just moved
  assign cur_occ = player ? r_out : b_out;

  win_check u_win_check (
    .occ       (cur_occ),
    .line_done (line_done)
  );

  assign timeout_hit = (TURN_TIMEOUT != 0) && (turn_cnt == TO_LAST);

  assign clr_game  = (state == S_CLEAR);
  assign we        = (state == S_WRITE);
  assign game_over = (state == S_DONE);
  assign data_in   = 1'b1;
  assign state_dbg = state;

  // Main controller FSM with registered player/cursor/result outputs
  always_ff @(posedge clk or negedge clr_game_n) begin
    if (!clr_game_n) begin
      state    <= S_CLEAR;
      player   <= 1'b0;
      offset   <= CENTER_SLOT;
      illegal  <= 1'b0;
      winner   <= WIN_NONE;
      turn_cnt <= '0;
    end else begin
      illegal <= 1'b0;
      if (new_game) begin
        state <= S_CLEAR;
      end else begin
        case (state)
          S_CLEAR: begin
            state    <= S_TURN;
            player   <= 1'b0;
            offset   <= CENTER_SLOT;
            winner   <= WIN_NONE;
            turn_cnt <= '0;
          end
          S_TURN: begin
            turn_cnt <= turn_cnt + 1'b1;
            if (select && !taken) begin
              // Accepted select beats both a simultaneous move and the timeout
              state <= S_WRITE;
            end else begin
              if (select) begin
                illegal <= 1'b1;
              end else if (move_right && !move_left) begin
                offset <= (offset == LAST_SLOT) ? 4'd0 : offset + 4'd1;
              end else if (move_left && !move_right) begin
                offset <= (offset == 4'd0) ? LAST_SLOT : offset - 4'd1;
              end
              if (timeout_hit) begin
                player   <= ~player;
                turn_cnt <= '0;
              end
            end
          end
          S_WRITE: begin
            state <= S_EVAL;
          end
          S_EVAL: begin
            if (line_done) begin
              state  <= S_DONE;
              winner <= player ? WIN_RED : WIN_BLUE;
            end else if ((b_out | r_out) == FULL_BOARD) begin
              state  <= S_DONE;
              winner <= WIN_DRAW;
            end else begin
              state    <= S_TURN;
              player   <= ~player;
              turn_cnt <= '0;
            end
          end
          S_DONE: begin
            state <= S_DONE;
          end
          default: begin
            state <= S_CLEAR;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: one instance with the timeout disabled and one
// with TURN_TIMEOUT = 16, each attached to its own board model.
module tb_game_ctrl;
  import game_pkg::*;

  logic clk;
  logic clr_game_n;
  logic move_left, move_right, select, new_game;

  // Instance 0 (no timeout)
  logic        taken0, player0, we0, data_in0, clr0, illegal0, game_over0;
  logic [3:0]  offset0;
  logic [1:0]  winner0;
  logic [8:0]  b0, r0, occ0;
  game_state_e state0;

  // Instance 1 (TURN_TIMEOUT = 16)
  logic        taken1, player1, we1, data_in1, clr1, illegal1, game_over1;
  logic [3:0]  offset1;
  logic [1:0]  winner1;
  logic [8:0]  b1, r1, occ1;
  game_state_e state1;

  int total = 0;
  int bad   = 0;
  int we_cnt0 = 0;
  int we_cnt1 = 0;
  int cur = 4;
  int snap;

  game_ctrl u_dut0 (
    .clk(clk), .clr_game_n(clr_game_n), .move_left(move_left), .move_right(move_right),
    .select(select), .new_game(new_game), .taken(taken0), .b_out(b0), .r_out(r0),
    .player(player0), .offset(offset0), .we(we0), .data_in(data_in0), .clr_game(clr0),
    .illegal(illegal0), .winner(winner0), .game_over(game_over0), .state_dbg(state0)
  );

  game_ctrl #(.TURN_TIMEOUT(16)) u_dut1 (
    .clk(clk), .clr_game_n(clr_game_n), .move_left(move_left), .move_right(move_right),
    .select(select), .new_game(new_game), .taken(taken1), .b_out(b1), .r_out(r1),
    .player(player1), .offset(offset1), .we(we1), .data_in(data_in1), .clr_game(clr1),
    .illegal(illegal1), .winner(winner1), .game_over(game_over1), .state_dbg(state1)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board models: synchronous clear, one-bit write per we cycle
  always @(posedge clk) begin
    if (clr0) begin
      b0 <= '0; r0 <= '0;
    end else if (we0) begin
      if (player0) r0[offset0] <= 1'b1;
      else         b0[offset0] <= 1'b1;
    end
    if (clr1) begin
      b1 <= '0; r1 <= '0;
    end else if (we1) begin
      if (player1) r1[offset1] <= 1'b1;
      else         b1[offset1] <= 1'b1;
    end
    if (we0) we_cnt0 <= we_cnt0 + 1;
    if (we1) we_cnt1 <= we_cnt1 + 1;
  end

  assign occ0   = b0 | r0;
  assign occ1   = b1 | r1;
  assign taken0 = occ0[offset0];
  assign taken1 = occ1[offset1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_right();
    move_right = 1'b1; tick(); move_right = 1'b0;
    cur = (cur == 8) ? 0 : cur + 1;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1; tick(); new_game = 1'b0;
    cur = 4;
  endtask

  // Walk the cursor to a slot, claim it, and run through WRITE and EVAL
  task automatic play(input int slot);
    while (cur != slot) pulse_right();
    select = 1'b1; tick(); select = 1'b0;
    check($sformatf("we_on_select_slot%0d", slot), {31'd0, we0}, 32'd1);
    tick();
    tick();
  endtask

  initial begin
    clr_game_n = 1'b0;
    move_left = 1'b0; move_right = 1'b0; select = 1'b0; new_game = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_clr_game", {31'd0, clr0}, 32'd1);
    check("rst_offset", {28'd0, offset0}, 32'd4);
    check("rst_player", {31'd0, player0}, 32'd0);
    check("rst_we", {31'd0, we0}, 32'd0);
    check("rst_winner", {30'd0, winner0}, 32'd0);
    check("rst_game_over", {31'd0, game_over0}, 32'd0);
    check("rst_illegal", {31'd0, illegal0}, 32'd0);
    check("data_in_tied", {31'd0, data_in0}, 32'd1);
    clr_game_n = 1'b1;
    check("release_clr_game_first", {31'd0, clr0}, 32'd1);
    tick();
    check("release_clr_game_done", {31'd0, clr0}, 32'd0);
    check("release_state", {29'd0, state0}, {29'd0, S_TURN});
    check("release_offset", {28'd0, offset0}, 32'd4);
    check("release_player", {31'd0, player0}, 32'd0);

    // Cursor wrap
    repeat (5) pulse_right();
    check("wrap_right_to_0", {28'd0, offset0}, 32'd0);
    move_left = 1'b1; tick(); move_left = 1'b0;
    check("wrap_left_to_8", {28'd0, offset0}, 32'd8);
    move_left = 1'b1; move_right = 1'b1; tick(); move_left = 1'b0; move_right = 1'b0;
    check("both_moves_ignored", {28'd0, offset0}, 32'd8);
    cur = 8;

    // Illegal move: blue takes 4, red tries 4
    play(4);
    check("after_blue_player", {31'd0, player0}, 32'd1);
    snap = we_cnt0;
    select = 1'b1; tick(); select = 1'b0;
    check("illegal_pulse", {31'd0, illegal0}, 32'd1);
    check("illegal_no_we", {31'd0, we0}, 32'd0);
    tick();
    check("illegal_one_cycle", {31'd0, illegal0}, 32'd0);
    repeat (5) tick();
    check("illegal_player_stays", {31'd0, player0}, 32'd1);
    check("illegal_we_count", we_cnt0, snap);

    // Blue wins row 0-1-2
    pulse_new_game();
    check("ng_clr_game", {31'd0, clr0}, 32'd1);
    tick();
    check("ng_offset", {28'd0, offset0}, 32'd4);
    check("ng_player", {31'd0, player0}, 32'd0);
    check("ng_board_clear", {23'd0, occ0}, 32'd0);
    play(0); play(3); play(1); play(4);
    check("row_pre_winner", {30'd0, winner0}, 32'd0);
    check("row_pre_game_over", {31'd0, game_over0}, 32'd0);
    play(2);
    check("row_winner_blue", {30'd0, winner0}, {30'd0, WIN_BLUE});
    check("row_game_over", {31'd0, game_over0}, 32'd1);
    check("row_state_done", {29'd0, state0}, {29'd0, S_DONE});
    snap = we_cnt0;
    select = 1'b1; tick(); select = 1'b0;
    move_right = 1'b1; tick(); move_right = 1'b0;
    select = 1'b1; tick(); select = 1'b0;
    tick();
    check("done_no_we", we_cnt0, snap);
    check("done_offset_frozen", {28'd0, offset0}, 32'd2);
    check("done_still_over", {31'd0, game_over0}, 32'd1);

    // Draw
    pulse_new_game();
    tick();
    play(0); play(1); play(2); play(4); play(3); play(5); play(7); play(6);
    check("draw_pre_winner", {30'd0, winner0}, 32'd0);
    play(8);
    check("draw_winner", {30'd0, winner0}, {30'd0, WIN_DRAW});
    check("draw_game_over", {31'd0, game_over0}, 32'd1);
    check("draw_board_full", {23'd0, occ0}, 32'h1FF);

    // Timeout on instance 1
    pulse_new_game();
    tick();
    snap = we_cnt1;
    check("to_start_player", {31'd0, player1}, 32'd0);
    repeat (15) tick();
    check("to_before_expiry", {31'd0, player1}, 32'd0);
    tick();
    check("to_player_toggled", {31'd0, player1}, 32'd1);
    check("to_no_we", we_cnt1, snap);
    check("no_to_player_stays", {31'd0, player0}, 32'd0);

    // new_game during WRITE on instance 1
    select = 1'b1; tick(); select = 1'b0;
    check("wr_we", {31'd0, we1}, 32'd1);
    check("wr_player", {31'd0, player1}, 32'd1);
    check("wr_offset", {28'd0, offset1}, 32'd4);
    new_game = 1'b1; tick(); new_game = 1'b0;
    check("wr_ng_write_landed", {23'd0, r1}, 32'h010);
    check("wr_ng_clr_game", {31'd0, clr1}, 32'd1);
    check("wr_ng_we_off", {31'd0, we1}, 32'd0);
    tick();
    check("wr_ng_turn", {29'd0, state1}, {29'd0, S_TURN});
    check("wr_ng_player", {31'd0, player1}, 32'd0);
    check("wr_ng_offset", {28'd0, offset1}, 32'd4);
    check("wr_ng_board_cleared", {23'd0, occ1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Turn-sequencing controller that sits directly upstream of the board register file. It turns debounced cursor/select pulses into single-cycle slot writes for the current player, and rejects moves onto occupied slots using the board's `taken` flag. It reads back both players' 9-bit occupancy vectors to detect a win or a draw, and drives the board's clear.

## Interface
Parameters:
- `TURN_TIMEOUT`, default 0: cycles allowed per turn before forfeit; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; all state is updated on its rising edge.
- `clr_game_n`  in  1  asynchronous, active-low reset.
- `move_left`  in  1  one-cycle pulse: move cursor down one slot.
- `move_right`  in  1  one-cycle pulse: move cursor up one slot.
- `select`  in  1  one-cycle pulse: claim the slot under the cursor.
- `new_game`  in  1  one-cycle pulse: synchronous restart.
- `taken`  in  1  from board: slot at `offset` is occupied by either player.
- `b_out`  in  9  from board: blue occupancy, bit i = slot i.
- `r_out`  in  9  from board: red occupancy, bit i = slot i.
- `player`  out  1  current player (0 blue, 1 red); drives the board address.
- `offset`  out  4  cursor slot, 0..8; drives the board offset.
- `we`  out  1  board write enable.
- `data_in`  out  1  board write data; tied to 1.
- `clr_game`  out  1  board clear.
- `illegal`  out  1  one-cycle pulse: select was rejected because the slot is taken.
- `winner`  out  2  00 none, 01 blue, 10 red, 11 draw.
- `game_over`  out  1  high while in DONE.

## Operation
States and transitions:
- CLEAR
  - `clr_game` = 1.
  - Next cycle: go to TURN with `player` = 0, `offset` = 4, `winner` = 00.
- TURN: waits for input.
  - `select` with `taken` = 0: go to WRITE.
  - `select` with `taken` = 1: pulse `illegal` and stay in TURN.
  - `select` has priority over a move in the same cycle; the move is dropped.
  - `move_right`: `offset` 8 wraps to 0.
  - `move_left`: `offset` 0 wraps to 8.
  - `move_left` and `move_right` in the same cycle: both ignored.
- WRITE
  - `we` = 1 for exactly one cycle; `player` and `offset` are held stable.
  - Next cycle: go to EVAL.
- EVAL: samples the updated `b_out`/`r_out` and tests the current player's vector against the 8 win masks (rows 0-1-2, 3-4-5, 6-7-8; columns 0-3-6, 1-4-7, 2-5-8; diagonals 0-4-8, 2-4-6).
  - Any mask fully covered: go to DONE with `winner` = player+1.
  - Otherwise, if (`b_out` | `r_out`) == 9'h1FF: go to DONE with `winner` = 11. A win on the final move takes precedence over a draw.
  - Otherwise: toggle `player` and return to TURN. The cursor is unchanged.
- DONE
  - `game_over` = 1.
  - All move and select inputs are ignored; only `new_game` leaves this state.

Global rules:
- `new_game` in any state goes to CLEAR next cycle. This includes mid-WRITE: the write completes at that edge and the clear follows.
- Timeout (`TURN_TIMEOUT` ≠ 0):
  - The turn counter zeroes on every entry to TURN.
  - It increments each cycle spent in TURN.
  - When it reaches `TURN_TIMEOUT`-1 with no accepted select, toggle `player` and re-enter TURN.
  - `select` accepted in that same cycle wins over the timeout.

## Timing
- Reset values:
  - state = CLEAR, so `clr_game` = 1 during reset and for the first cycle after release.
  - `player` = 0, `offset` = 4, `we` = 0, `illegal` = 0, `winner` = 00, `game_over` = 0, counter = 0.
- Output decoding:
  - `clr_game`, `we` and `game_over` are decoded from the registered state.
  - `illegal` is registered and appears the cycle after the rejected select.
  - `winner` is registered at the EVAL→DONE edge.
- Latency:
  - select sampled at edge N → `we` high N+1..N+2 → board written at N+2 → EVAL during N+2..N+3.
  - Back in TURN (or DONE) from N+3, i.e. 3 cycles per accepted move.
- Inputs are sampled only in their listed states. A pulse arriving during WRITE or EVAL is lost; no buffering.
- `offset` never leaves 0..8. The upper encodings 9..15 are unreachable.

## Structure
- `game_pkg`:
  - state enum
  - winner codes (`WIN_NONE`, `WIN_BLUE`, `WIN_RED`, `WIN_DRAW`)
  - `CENTER_SLOT` = 4, `LAST_SLOT` = 8, `FULL_BOARD` = 9'h1FF
  - `WIN_LINES`: constant array of eight 9-bit masks.
- Sub-module `win_check`: combinational; 9-bit vector in, 1-bit "line complete" out; iterates `WIN_LINES`. It is shared with any future display logic.

## Test plan
- Reset release: `clr_game` = 1 for exactly one cycle, then `offset` = 4, `player` = 0, `winner` = 00.
- Cursor wrap: 5 `move_right` from 4 → `offset` 0; one `move_left` → 8; simultaneous left+right → unchanged.
- Blue wins row: with a board model attached, blue 0, red 3, blue 1, red 4, blue 2 → `winner` = 01, `game_over` = 1. Further selects produce no `we`.
- Illegal move: red selects slot 4 already held by blue → `illegal` pulses once, no `we`, `player` stays 1.
- Draw: fill sequence 0,1,2,4,3,5,7,6,8 → `winner` = 11 after the 9th EVAL.
- `TURN_TIMEOUT` = 16: idle for 16 cycles → `player` toggles, no `we`. `new_game` asserted during WRITE → write lands, then `clr_game` pulse, then TURN with `player` = 0.
